// File: rtl/tlm_hdl_if_pkg.sv
// rtl/tlm_hdl_if_pkg.sv - shared types and helpers for the HDL->HVL TLM arbiter
package tlm_hdl_if_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } tlm_arb_state_e;

  // Index width for n entries, never narrower than one bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tlm_rr_pick.sv
// rtl/tlm_rr_pick.sv - combinational round-robin picker starting at ptr
module tlm_rr_pick
  import tlm_hdl_if_pkg::*;
#(
  parameter int N = 2,
  localparam int IDW = clog2_min1(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           gnt_any,
  output logic [IDW-1:0] gnt_idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDW:0]   off;
  logic [IDW:0]   sum;
  logic           found;

  // Rotate the request vector so ptr sits at bit 0, take the lowest set bit,
  // then map that offset back to an absolute index with a compare-based wrap
  always_comb begin
    dbl   = {req, req};
    rot   = '0;
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      rot[i] = dbl[{1'b0, ptr} + (IDW + 1)'(i)];
    end
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        off   = (IDW + 1)'(i);
        found = 1'b1;
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IDW + 1)'(N)) sum = sum - (IDW + 1)'(N);
    gnt_any = |req;
    gnt_idx = sum[IDW-1:0];
  end

endmodule

// File: rtl/tlm_hdl2hvl_arb.sv
// rtl/tlm_hdl2hvl_arb.sv - round-robin burst arbiter feeding one HDL->HVL fifo
module tlm_hdl2hvl_arb
  import tlm_hdl_if_pkg::*;
#(
  parameter int Twidth = 32,
  parameter int Nreq = 2,
  localparam int idw = clog2_min1(Nreq)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [Nreq-1:0]        req_valid,
  output logic [Nreq-1:0]        req_ready,
  input  logic [Nreq*Twidth-1:0] req_dat,
  input  logic [Nreq-1:0]        req_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [Twidth-1:0]      out_dat,
  output logic [idw-1:0]         out_id,
  output logic                   out_last,
  output logic                   busy
);

  tlm_arb_state_e    state_q, state_d;
  logic [idw-1:0]    owner_q, owner_d;
  logic [idw-1:0]    rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [Twidth-1:0] out_dat_q, out_dat_d;
  logic [idw-1:0]    out_id_q, out_id_d;
  logic              out_last_q, out_last_d;

  logic              pick_any;
  logic [idw-1:0]    pick_idx;
  logic              can_load;
  logic              sel_ok;
  logic [idw-1:0]    sel_idx;
  logic [Twidth-1:0] sel_dat;
  logic              sel_last;
  logic              xfer;

  tlm_rr_pick #(.N(Nreq)) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt_any (pick_any),
    .gnt_idx (pick_idx)
  );

  // Steer ready to the round-robin winner, or to the lock owner mid-burst
  always_comb begin
    can_load  = !out_valid_q || out_ready;
    sel_ok    = (state_q == ARB_LOCKED) ? 1'b1 : pick_any;
    sel_idx   = (state_q == ARB_LOCKED) ? owner_q : pick_idx;
    req_ready = '0;
    if (!reset && sel_ok && can_load) req_ready[sel_idx] = 1'b1;
    xfer      = |(req_valid & req_ready);
    sel_dat   = '0;
    sel_last  = 1'b0;
    for (int i = 0; i < Nreq; i++) begin
      if (sel_idx == idw'(i)) begin
        sel_dat  = req_dat[i*Twidth +: Twidth];
        sel_last = req_last[i];
      end
    end
  end

  // Next-state: burst lock, pointer advance on burst end, output register load/drain
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_dat_d   = out_dat_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_dat_d   = sel_dat;
      out_id_d    = sel_idx;
      out_last_d  = sel_last;
      if (sel_last) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = (sel_idx == idw'(Nreq - 1)) ? '0 : sel_idx + idw'(1);
      end else begin
        state_d = ARB_LOCKED;
        owner_d = sel_idx;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers, cleared by synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_dat_q   <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_dat_q   <= out_dat_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_dat   = out_dat_q;
  assign out_id    = out_id_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == ARB_LOCKED) || out_valid_q;

endmodule

// File: tb/tb_tlm_hdl2hvl_arb.sv
// tb/tb_tlm_hdl2hvl_arb.sv - scoreboard bench for the round-robin fifo arbiter
module tb_tlm_hdl2hvl_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] dat;
    logic        last;
  } beat_t;

  beat_t exp2_q[$];
  beat_t exp4_q[$];
  int    cnt4[4];

  // Two-requester instance
  logic        rst2;
  logic [1:0]  v2, r2, l2;
  logic [63:0] d2;
  logic        ov2, ordy2, ol2, busy2;
  logic [31:0] od2;
  logic [0:0]  oid2;

  // Four-requester instance
  logic         rst4;
  logic [3:0]   v4, r4, l4;
  logic [127:0] d4;
  logic         ov4, ordy4, ol4, busy4;
  logic [31:0]  od4;
  logic [1:0]   oid4;

  tlm_hdl2hvl_arb #(.Twidth(32), .Nreq(2)) u_dut2 (
    .clock(clk), .reset(rst2), .req_valid(v2), .req_ready(r2), .req_dat(d2),
    .req_last(l2), .out_valid(ov2), .out_ready(ordy2), .out_dat(od2),
    .out_id(oid2), .out_last(ol2), .busy(busy2)
  );

  tlm_hdl2hvl_arb #(.Twidth(32), .Nreq(4)) u_dut4 (
    .clock(clk), .reset(rst4), .req_valid(v4), .req_ready(r4), .req_dat(d4),
    .req_last(l4), .out_valid(ov4), .out_ready(ordy4), .out_dat(od4),
    .out_id(oid4), .out_last(ol4), .busy(busy4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t mk(input int id, input logic [31:0] dat, input logic last);
    beat_t b;
    b.id   = 2'(id);
    b.dat  = dat;
    b.last = last;
    return b;
  endfunction

  // Monitor for the two-requester instance: pop on every accepted output beat
  always @(negedge clk) begin
    if (ov2 === 1'b1 && ordy2 === 1'b1) begin
      if (exp2_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m2_unexpected actual=%0h/id%0d expected=none", od2, oid2);
      end else begin
        beat_t e;
        e = exp2_q.pop_front();
        chk("m2_dat", 64'(od2), 64'(e.dat));
        chk("m2_id", 64'(oid2), 64'(e.id));
        chk("m2_last", 64'(ol2), 64'(e.last));
      end
    end
  end

  // Monitor for the four-requester instance, also tallying beats per id
  always @(negedge clk) begin
    if (ov4 === 1'b1 && ordy4 === 1'b1) begin
      cnt4[oid4]++;
      if (exp4_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m4_unexpected actual=%0h/id%0d expected=none", od4, oid4);
      end else begin
        beat_t e;
        e = exp4_q.pop_front();
        chk("m4_dat", 64'(od4), 64'(e.dat));
        chk("m4_id", 64'(oid4), 64'(e.id));
        chk("m4_last", 64'(ol4), 64'(e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) cnt4[i] = 0;
    rst2 = 1'b1; v2 = 2'b11; l2 = 2'b11; d2 = {32'hB0, 32'hA0}; ordy2 = 1'b1;
    rst4 = 1'b1; v4 = 4'h0; l4 = 4'hF; d4 = '0; ordy4 = 1'b1;

    // Reset held with every requester valid
    repeat (2) begin
      tick();
      @(negedge clk);
      chk("rst_out_valid", 64'(ov2), 64'd0);
      chk("rst_req_ready", 64'(r2), 64'd0);
      chk("rst_busy", 64'(busy2), 64'd0);
    end

    // Single-beat contention alternates A0/id0, B0/id1 at one beat per cycle
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) exp2_q.push_back(mk(0, 32'hA0, 1'b1));
      else            exp2_q.push_back(mk(1, 32'hB0, 1'b1));
    end
    rst2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) v2 = 2'b00;
      @(negedge clk);
      chk("contend_out_valid", 64'(ov2), 64'd1);
    end
    repeat (3) tick();
    chk("contend_drained", 64'(exp2_q.size()), 64'd0);

    // Burst from req0 holds the grant while req1 waits
    exp2_q.push_back(mk(0, 32'h10, 1'b0));
    exp2_q.push_back(mk(0, 32'h11, 1'b0));
    exp2_q.push_back(mk(0, 32'h12, 1'b1));
    exp2_q.push_back(mk(1, 32'h20, 1'b1));
    v2 = 2'b11; d2 = {32'h20, 32'h10}; l2 = 2'b10;
    @(negedge clk);
    chk("burst_ready_b0", 64'(r2), 64'b01);
    tick();
    d2[31:0] = 32'h11;
    @(negedge clk);
    chk("burst_ready_b1", 64'(r2), 64'b01);
    chk("burst_busy", 64'(busy2), 64'd1);
    tick();
    d2[31:0] = 32'h12; l2 = 2'b11;
    @(negedge clk);
    chk("burst_ready_b2", 64'(r2), 64'b01);
    tick();
    v2 = 2'b10;
    @(negedge clk);
    chk("burst_ready_req1", 64'(r2), 64'b10);
    tick();
    v2 = 2'b00;
    repeat (3) tick();
    chk("burst_drained", 64'(exp2_q.size()), 64'd0);

    // Backpressure holds 0x33 stable and blocks new grants
    exp2_q.push_back(mk(0, 32'h33, 1'b1));
    exp2_q.push_back(mk(1, 32'h44, 1'b1));
    ordy2 = 1'b0; v2 = 2'b01; d2 = {32'h44, 32'h33}; l2 = 2'b11;
    tick();
    v2 = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_out_dat", 64'(od2), 64'h33);
      chk("bp_req_ready", 64'(r2), 64'd0);
      tick();
    end
    ordy2 = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(r2), 64'b10);
    tick();
    v2 = 2'b00;
    @(negedge clk);
    chk("bp_next_valid", 64'(ov2), 64'd1);
    chk("bp_next_dat", 64'(od2), 64'h44);
    repeat (3) tick();
    chk("bp_drained", 64'(exp2_q.size()), 64'd0);

    // Reset in the middle of a req0 burst drops the held beat and the lock
    ordy2 = 1'b0; v2 = 2'b11; d2 = {32'h20, 32'h10}; l2 = 2'b10;
    tick();
    rst2 = 1'b1; v2 = 2'b10;
    @(negedge clk);
    chk("mid_rst_ready", 64'(r2), 64'd0);
    chk("mid_rst_busy_before", 64'(busy2), 64'd1);
    tick();
    rst2 = 1'b0; ordy2 = 1'b1;
    exp2_q.push_back(mk(1, 32'h20, 1'b1));
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(ov2), 64'd0);
    chk("mid_rst_busy_after", 64'(busy2), 64'd0);
    chk("mid_rst_grant_req1", 64'(r2), 64'b10);
    tick();
    v2 = 2'b00;
    repeat (3) tick();
    chk("mid_rst_drained", 64'(exp2_q.size()), 64'd0);

    // Four requesters all valid: strict 0,1,2,3 rotation
    v4 = 4'hF; l4 = 4'hF; d4 = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    @(negedge clk);
    chk("fair_rst_ready", 64'(r4), 64'd0);
    chk("fair_rst_valid", 64'(ov4), 64'd0);
    for (int i = 0; i < 12; i++) exp4_q.push_back(mk(i % 4, 32'hC0 + 32'(i % 4), 1'b1));
    rst4 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 11) v4 = 4'h0;
    end
    repeat (3) tick();
    chk("fair_drained", 64'(exp4_q.size()), 64'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("fair_count_id%0d", i), 64'(cnt4[i]), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
